// File: rtl/instr_mem_sync.sv
// Loadable, word-addressed instruction memory with a 1-cycle synchronous read,
// stall/flush output control, a program-load port and a post-reset clear sequencer.
module instr_mem_sync #(
  parameter int                DATA_W         = 32,
  parameter int                DEPTH          = 64,
  parameter logic [DATA_W-1:0] NOP_WORD       = {DATA_W{1'b0}},
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter string             INIT_FILE      = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fault,
  input  logic              ld_en,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [AW-1:0]     clr_idx_r;
  logic [AW-1:0]     clr_idx_nxt_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              busy_s;
  logic              fetch_ok_s;
  logic              ld_ok_s;
  logic [AW-1:0]     fetch_idx_s;
  logic [AW-1:0]     ld_idx_s;
  logic [DATA_W-1:0] rd_word_s;

  logic              wr_en_s;
  logic [AW-1:0]     wr_idx_s;
  logic [DATA_W-1:0] wr_data_s;

  logic [DATA_W-1:0] instr_r;
  logic              valid_r;
  logic              fault_r;
  logic              ld_ack_r;

  // A byte address is usable only when word-aligned and inside the array.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < 30'(DEPTH));
  endfunction

  assign busy_s      = (state_r == ST_CLEAR);
  assign fetch_ok_s  = addr_ok(pc);
  assign fetch_idx_s = pc[AW+1:2];
  assign ld_idx_s    = ld_addr[AW+1:2];
  assign ld_ok_s     = (state_r == ST_READY) && ld_en && addr_ok(ld_addr);
  assign rd_word_s   = mem_r[fetch_idx_s];

  // Sequencer state and clear index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_idx_r <= {AW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      clr_idx_r <= clr_idx_nxt_s;
    end
  end

  // Walk the clear index once; READY is terminal until the next reset.
  always_comb begin
    state_nxt_s   = state_r;
    clr_idx_nxt_s = clr_idx_r;
    case (state_r)
      ST_CLEAR: begin
        clr_idx_nxt_s = clr_idx_r + AW'(1);
        if (clr_idx_r == AW'(DEPTH - 1)) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_nxt_s   = ST_READY;
        clr_idx_nxt_s = clr_idx_r;
      end
      default: begin
        state_nxt_s   = ST_READY;
        clr_idx_nxt_s = {AW{1'b0}};
      end
    endcase
  end

  // Single write port shared by the clear sequencer and the load port;
  // nothing is written while rst is held so reset never alters contents.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = {AW{1'b0}};
    wr_data_s = NOP_WORD;
    if (rst) begin
      wr_en_s = 1'b0;
    end else if (busy_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = clr_idx_r;
      wr_data_s = NOP_WORD;
    end else if (ld_ok_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = ld_idx_s;
      wr_data_s = ld_data;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Array write; the fetch path samples the pre-edge word (read-first).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= wr_data_s;
    end
  end

  // Fetch output register: busy > flush > stall > fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_r  <= NOP_WORD;
      valid_r  <= 1'b0;
      fault_r  <= 1'b0;
      ld_ack_r <= 1'b0;
    end else begin
      ld_ack_r <= ld_ok_s;
      if (busy_s || flush) begin
        instr_r <= NOP_WORD;
        valid_r <= 1'b0;
        fault_r <= 1'b0;
      end else if (stall) begin
        instr_r <= instr_r;
        valid_r <= valid_r;
        fault_r <= fault_r;
      end else if (fetch_en) begin
        if (fetch_ok_s) begin
          instr_r <= rd_word_s;
          valid_r <= 1'b1;
          fault_r <= 1'b0;
        end else begin
          instr_r <= NOP_WORD;
          valid_r <= 1'b0;
          fault_r <= 1'b1;
        end
      end else begin
        instr_r <= instr_r;
        valid_r <= 1'b0;
        fault_r <= 1'b0;
      end
    end
  end

  assign instr       = instr_r;
  assign instr_valid = valid_r;
  assign fault       = fault_r;
  assign ld_ack      = ld_ack_r;
  assign busy        = busy_s;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync: behavioural model checked every cycle,
// a vector table for fetch/stall/flush/fault cases, and directed reset/load sequences.
module tb_instr_mem_sync;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, fetch_en, stall, flush, ld_en;
  logic [31:0] pc, ld_addr, ld_data, instr;
  logic        instr_valid, fault, ld_ack, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          busy_left;
  logic [31:0] m_instr;
  logic        m_valid, m_fault, m_ack;

  always #5 clk = ~clk;

  instr_mem_sync #(
    .DATA_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall), .flush(flush), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .fault(fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack), .busy(busy)
  );

  typedef struct {
    bit          fe, st, fl;
    logic [31:0] p;
    logic [31:0] e_instr;
    bit          e_valid, e_fault;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ok_addr(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  function automatic logic [31:0] prog_word(input int i);
    if (i == 0) return 32'h2008_0000;
    if (i == 1) return 32'h200d_0050;
    return 32'hA500_0000 + 32'(i);
  endfunction

  // Advance the model by one edge using the current inputs, then compare.
  task automatic tick();
    logic [31:0] old;
    if (rst) begin
      m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0; m_ack = 1'b0;
      busy_left = DEPTH;
    end else if (busy_left > 0) begin
      ref_mem[DEPTH - busy_left] = NOP;
      busy_left--;
      m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0; m_ack = 1'b0;
    end else begin
      old = ok_addr(pc) ? ref_mem[pc / 4] : NOP;
      if (flush) begin
        m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0;
      end else if (stall) begin
        m_instr = m_instr;
      end else if (fetch_en) begin
        if (ok_addr(pc)) begin
          m_instr = old; m_valid = 1'b1; m_fault = 1'b0;
        end else begin
          m_instr = NOP; m_valid = 1'b0; m_fault = 1'b1;
        end
      end else begin
        m_valid = 1'b0; m_fault = 1'b0;
      end
      m_ack = ld_en && ok_addr(ld_addr);
      if (m_ack) ref_mem[ld_addr / 4] = ld_data;
    end
    @(posedge clk);
    #1;
    check("model_instr", instr, m_instr);
    check("model_valid", 32'(instr_valid), 32'(m_valid));
    check("model_fault", 32'(fault), 32'(m_fault));
    check("model_ld_ack", 32'(ld_ack), 32'(m_ack));
    check("model_busy", 32'(busy), 32'(busy_left > 0));
  endtask

  task automatic drive(input bit fe, input bit st, input bit fl, input logic [31:0] p,
                       input bit le, input logic [31:0] la, input logic [31:0] ldd);
    fetch_en = fe; stall = st; flush = fl; pc = p;
    ld_en = le; ld_addr = la; ld_data = ldd;
    tick();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; fetch_en = 1'b0; stall = 1'b0; flush = 1'b0; pc = 32'h0;
    ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
    m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0; m_ack = 1'b0; busy_left = DEPTH;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h04,  32'h200d_0050, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h08,  32'hA500_0002, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0C,  32'hA500_0002, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h10,  32'hA500_0002, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h14,  32'hA500_0002, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h18,  NOP,           1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h102, NOP,           1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h100, NOP,           1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h00,  32'h2008_0000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h04,  32'h2008_0000, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h44,  32'hA500_0011, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h48,  NOP,           1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'hFC,  NOP,           1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 32'h04,  NOP,           1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h101, NOP,           1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h04,  NOP,           1'b0, 1'b1};

    // Reset state, then the clear sequence with fetches and a dropped load.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("reset_instr", instr, NOP);
    check("reset_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check("busy_during_clear", 32'(busy), 32'd1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, (i == 40), 32'h08, 32'h5555_5555);
      check("valid_during_clear", 32'(instr_valid), 32'd0);
    end
    check("busy_done", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("first_fetch", instr, 32'h0);
    check("first_fetch_valid", 32'(instr_valid), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'h08, 1'b0, 32'h0, 32'h0);
    check("busy_load_dropped", instr, NOP);

    // Program load of words 0..17.
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 4), prog_word(i));
      cnt += int'(ld_ack);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("ld_ack_low_after", 32'(ld_ack), 32'd0);
    check("ld_ack_count", 32'(cnt), 32'd18);

    // Vector table: fetch, stall, flush, fault and idle behaviour.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].fe, tbl[i].st, tbl[i].fl, tbl[i].p, 1'b0, 32'h0, 32'h0);
      check($sformatf("vec%0d_instr", i), instr, tbl[i].e_instr);
      check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d_fault", i), 32'(fault), 32'(tbl[i].e_fault));
    end

    // Same-cycle load and fetch of one word is read-first; loads go through a stall.
    drive(1'b1, 1'b0, 1'b0, 32'h0C, 1'b1, 32'h0C, 32'hDEAD_BEEF);
    check("rf_old", instr, 32'hA500_0003);
    check("rf_ack", 32'(ld_ack), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'h0C, 1'b0, 32'h0, 32'h0);
    check("rf_new", instr, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h10, 32'h1234_5678);
    check("stall_load_ack", 32'(ld_ack), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0E, 32'h1);
    check("misaligned_load_nack", 32'(ld_ack), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h100, 32'h1);
    check("stall_load_data", instr, 32'h1234_5678);
    check("range_load_nack", 32'(ld_ack), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      drive(1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            32'($urandom_range(0, 69) * 4 + (($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0)),
            ($urandom_range(0, 3) == 0),
            32'($urandom_range(0, 69) * 4 + (($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0)),
            $urandom);
    end
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      cnt++;
    end
    check("random_settle", 32'(busy), 32'd0);

    // Reset in the middle of a clear restarts it from index 0.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      drive(1'b1, 1'b0, 1'b0, 32'h14, (cnt == 40), 32'h14, 32'hCAFE_F00D);
      check("busy_load_nack", 32'(ld_ack), 32'd0);
      cnt++;
    end
    check("restart_busy_cycles", 32'(cnt), 32'(DEPTH));
    drive(1'b1, 1'b0, 1'b0, 32'h14, 1'b0, 32'h0, 32'h0);
    check("busy_load_no_write", instr, NOP);
    check("busy_load_no_write_valid", 32'(instr_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
